// File: rtl/sipo_deserializer_if.sv
// Handshake bundle between a serial producer, the deserializer and a parallel consumer.
// The master side drives the serial bits, clr and p_ready; the slave side is the deserializer.
interface sipo_deserializer_if #(
   parameter int WIDTH = 4
);
   logic             clr;
   logic             s_valid;
   logic             s_bit;
   logic             s_ready;
   logic             p_valid;
   logic             p_ready;
   logic [WIDTH-1:0] p_data;
   logic             busy;

   modport master (
      output clr, s_valid, s_bit, p_ready,
      input  s_ready, p_valid, p_data, busy
   );

   modport slave (
      input  clr, s_valid, s_bit, p_ready,
      output s_ready, p_valid, p_data, busy
   );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer with a one-word holding register.
// Each word shifts in one bit per handshake and is then presented on p_data with valid/ready flow control.
module sipo_deserializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   sipo_deserializer_if.slave  bus
);
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] r_sr;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_p_data;
   logic             r_p_valid;

   logic [WIDTH-1:0] w_shifted;
   logic             w_last_bit;
   logic             w_s_ready;
   logic             w_accept;
   logic             w_complete;
   logic             w_pop;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_shifted = {r_sr[WIDTH-2:0], bus.s_bit};
      end else begin : g_lsb_first
         assign w_shifted = {bus.s_bit, r_sr[WIDTH-1:1]};
      end
   endgenerate

   // Stall only the final bit, and only while the held word is not draining this cycle.
   assign w_last_bit = (r_cnt == LAST);
   assign w_s_ready  = !(w_last_bit && r_p_valid && !bus.p_ready);
   assign w_accept   = bus.s_valid && w_s_ready && !bus.clr;
   assign w_complete = w_accept && w_last_bit;
   assign w_pop      = r_p_valid && bus.p_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (bus.clr) begin
         r_sr  <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_sr  <= w_shifted;
         r_cnt <= w_complete ? '0 : r_cnt + CW'(1);
      end
   end

   // A completing word wins over a pop on the same edge, so back-to-back words see no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p_data  <= '0;
         r_p_valid <= 1'b0;
      end else if (w_complete) begin
         r_p_data  <= w_shifted;
         r_p_valid <= 1'b1;
      end else if (w_pop) begin
         r_p_valid <= 1'b0;
      end
   end

   assign bus.s_ready = w_s_ready;
   assign bus.p_valid = r_p_valid;
   assign bus.p_data  = r_p_data;
   assign bus.busy    = (r_cnt != '0);
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: an MSB-first and an LSB-first instance receive identical stimulus.
// Inputs change on the falling edge and outputs are sampled there, away from the active edge.
module tb_sipo_deserializer;
   logic clk = 1'b0;
   logic rst_n;
   int   tests_run = 0;
   int   fails     = 0;

   sipo_deserializer_if #(.WIDTH(4)) im ();
   sipo_deserializer_if #(.WIDTH(4)) il ();

   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (im.slave)
   );

   sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (il.slave)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic b, input logic c, input logic pr);
      im.s_valid = v; im.s_bit = b; im.clr = c; im.p_ready = pr;
      il.s_valid = v; il.s_bit = b; il.clr = c; il.p_ready = pr;
   endtask

   task automatic send_bit(input logic b);
      drive(1'b1, b, 1'b0, im.p_ready);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, im.p_ready);
   endtask

   task automatic flush();
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk); @(negedge clk);
      tests_run++; if (im.p_valid !== 1'b0) begin fails++; $display("FAIL rst_p_valid: got %b expected 0", im.p_valid); end
      tests_run++; if (im.p_data !== 4'h0) begin fails++; $display("FAIL rst_p_data: got %h expected 0", im.p_data); end
      tests_run++; if (im.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", im.busy); end
      tests_run++; if (im.s_ready !== 1'b1) begin fails++; $display("FAIL rst_s_ready: got %b expected 1", im.s_ready); end
      rst_n = 1'b1;
      @(negedge clk);
      send_bit(1'b1); send_bit(1'b0);
      tests_run++; if (im.busy !== 1'b1) begin fails++; $display("FAIL rst_midword_busy: got %b expected 1", im.busy); end
      #2 rst_n = 1'b0;
      #1;
      tests_run++; if (im.busy !== 1'b0) begin fails++; $display("FAIL rst_async_busy: got %b expected 0", im.busy); end
      tests_run++; if (im.s_ready !== 1'b1) begin fails++; $display("FAIL rst_async_s_ready: got %b expected 1", im.s_ready); end
      tests_run++; if (im.p_valid !== 1'b0) begin fails++; $display("FAIL rst_async_p_valid: got %b expected 0", im.p_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      tests_run++; if (im.p_valid !== 1'b1) begin fails++; $display("FAIL rst_after_p_valid: got %b expected 1", im.p_valid); end
      tests_run++; if (im.p_data !== 4'hB) begin fails++; $display("FAIL rst_after_p_data: got %h expected b", im.p_data); end
   endtask

   task automatic test_msb_first();
      flush();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      tests_run++; if (im.p_valid !== 1'b0) begin fails++; $display("FAIL msb_early_valid: got %b expected 0", im.p_valid); end
      tests_run++; if (im.busy !== 1'b1) begin fails++; $display("FAIL msb_busy: got %b expected 1", im.busy); end
      send_bit(1'b1);
      tests_run++; if (im.p_valid !== 1'b1) begin fails++; $display("FAIL msb_p_valid: got %b expected 1", im.p_valid); end
      tests_run++; if (im.p_data !== 4'hD) begin fails++; $display("FAIL msb_p_data: got %h expected d", im.p_data); end
      tests_run++; if (im.busy !== 1'b0) begin fails++; $display("FAIL msb_busy_done: got %b expected 0", im.busy); end
      @(negedge clk);
      tests_run++; if (im.p_valid !== 1'b0) begin fails++; $display("FAIL msb_one_cycle: got %b expected 0", im.p_valid); end
   endtask

   task automatic test_lsb_first();
      flush();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      tests_run++; if (il.p_valid !== 1'b1) begin fails++; $display("FAIL lsb_p_valid: got %b expected 1", il.p_valid); end
      tests_run++; if (il.p_data !== 4'hB) begin fails++; $display("FAIL lsb_p_data: got %h expected b", il.p_data); end
   endtask

   task automatic test_backpressure();
      flush();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      tests_run++; if (im.p_data !== 4'hA) begin fails++; $display("FAIL bp_first_word: got %h expected a", im.p_data); end
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      tests_run++; if (im.s_ready !== 1'b0) begin fails++; $display("FAIL bp_s_ready_low: got %b expected 0", im.s_ready); end
      tests_run++; if (im.busy !== 1'b1) begin fails++; $display("FAIL bp_busy: got %b expected 1", im.busy); end
      tests_run++; if (im.p_data !== 4'hA) begin fails++; $display("FAIL bp_hold: got %h expected a", im.p_data); end
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      tests_run++; if (im.p_data !== 4'hA) begin fails++; $display("FAIL bp_stalled_data: got %h expected a", im.p_data); end
      tests_run++; if (im.p_valid !== 1'b1) begin fails++; $display("FAIL bp_stalled_valid: got %b expected 1", im.p_valid); end
      tests_run++; if (im.s_ready !== 1'b0) begin fails++; $display("FAIL bp_still_low: got %b expected 0", im.s_ready); end
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      tests_run++; if (im.s_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_comb: got %b expected 1", im.s_ready); end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      tests_run++; if (im.p_valid !== 1'b1) begin fails++; $display("FAIL bp_new_valid: got %b expected 1", im.p_valid); end
      tests_run++; if (im.p_data !== 4'h7) begin fails++; $display("FAIL bp_new_data: got %h expected 7", im.p_data); end
      tests_run++; if (im.busy !== 1'b0) begin fails++; $display("FAIL bp_new_busy: got %b expected 0", im.busy); end
   endtask

   task automatic test_back_to_back();
      flush();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      tests_run++; if (im.p_data !== 4'h5) begin fails++; $display("FAIL b2b_first: got %h expected 5", im.p_data); end
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++; if (im.p_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b expected 1", im.p_valid); end
      tests_run++; if (im.p_data !== 4'h3) begin fails++; $display("FAIL b2b_data: got %h expected 3", im.p_data); end
      tests_run++; if (il.p_data !== 4'hC) begin fails++; $display("FAIL b2b_lsb_data: got %h expected c", il.p_data); end
   endtask

   task automatic test_clear();
      flush();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      tests_run++; if (im.p_data !== 4'h9) begin fails++; $display("FAIL clr_held: got %h expected 9", im.p_data); end
      send_bit(1'b1); send_bit(1'b1);
      tests_run++; if (im.busy !== 1'b1) begin fails++; $display("FAIL clr_busy_before: got %b expected 1", im.busy); end
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      tests_run++; if (im.s_ready !== 1'b1) begin fails++; $display("FAIL clr_s_ready: got %b expected 1", im.s_ready); end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++; if (im.busy !== 1'b0) begin fails++; $display("FAIL clr_busy_after: got %b expected 0", im.busy); end
      tests_run++; if (im.p_data !== 4'h9) begin fails++; $display("FAIL clr_p_data_kept: got %h expected 9", im.p_data); end
      tests_run++; if (im.p_valid !== 1'b1) begin fails++; $display("FAIL clr_p_valid_kept: got %b expected 1", im.p_valid); end
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      tests_run++; if (im.s_ready !== 1'b0) begin fails++; $display("FAIL clr_count_restart: got %b expected 0", im.s_ready); end
      tests_run++; if (im.p_data !== 4'h9) begin fails++; $display("FAIL clr_p_data_mid: got %h expected 9", im.p_data); end
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++; if (im.p_data !== 4'h6) begin fails++; $display("FAIL clr_new_word: got %h expected 6", im.p_data); end
      tests_run++; if (im.p_valid !== 1'b1) begin fails++; $display("FAIL clr_new_valid: got %b expected 1", im.p_valid); end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_backpressure();
      test_back_to_back();
      test_clear();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
